// File: rtl/mainmem_ctrl.sv
// mainmem_ctrl: fixed-latency main-memory model sitting behind a cache.
// One access at a time: IDLE accepts a request, BUSY counts LATENCY cycles,
// DONE inserts a one-cycle gap before the next request can be taken.
// LATENCY must lie in 1..15 because the countdown counter is 4 bits wide.
// Optional feature: define MAINMEM_ERR_EN to add the mem_err output and
// misaligned/out-of-range address checking. Without it, the unused address
// bits are silently dropped.
module mainmem_ctrl #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mainmem_access,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] reg_data,
    output logic        mainmem_busy,
    output logic [31:0] dram_data
`ifdef MAINMEM_ERR_EN
    ,
    output logic        mem_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [3:0]           cnt_q, cnt_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic                 busy_q, busy_d;
    logic [31:0]          dram_q, dram_d;
    logic [ADDR_BITS-1:0] idx;
    logic                 accept;
    logic                 complete;
    logic                 err;

    // Word array; deliberately has no reset so contents survive rst.
    logic [31:0] mem_array [DEPTH];

`ifdef MAINMEM_ERR_EN
    logic [31:0] addr_q, addr_d;
    logic        mem_err_q, mem_err_d;

    // The whole address is kept so the completion edge can judge alignment and range.
    assign idx     = addr_q[ADDR_BITS+1:2];
    assign err     = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_BITS + 2)) != 32'd0);
    assign mem_err = mem_err_q;
`else
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic                 unused_addr;

    // Only the word index is kept; byte-offset and high address bits are dropped.
    assign idx         = idx_q;
    assign err         = 1'b0;
    assign unused_addr = &{1'b0, addr};
`endif

    assign accept       = (state_q == IDLE) && mainmem_access && (re || we);
    assign complete     = (state_q == BUSY) && (cnt_q == 4'd0);
    assign mainmem_busy = busy_q;
    assign dram_data    = dram_q;

    // State and datapath registers, cleared immediately by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            wdata_q   <= 32'd0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            dram_q    <= 32'd0;
`ifdef MAINMEM_ERR_EN
            addr_q    <= 32'd0;
            mem_err_q <= 1'b0;
`else
            idx_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
            dram_q    <= dram_d;
`ifdef MAINMEM_ERR_EN
            addr_q    <= addr_d;
            mem_err_q <= mem_err_d;
`else
            idx_q     <= idx_d;
`endif
        end
    end

    // Next-state logic: IDLE -> BUSY on a qualified request, BUSY -> DONE when the count expires, DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the request on accept, count down while busy, finish the latched op at count zero.
    always_comb begin
        cnt_d     = cnt_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        busy_d    = busy_q;
        dram_d    = dram_q;
`ifdef MAINMEM_ERR_EN
        addr_d    = addr_q;
        mem_err_d = 1'b0;
`else
        idx_d     = idx_q;
`endif
        if (accept) begin
            cnt_d   = 4'(LATENCY - 1);
            wdata_d = reg_data;
            write_d = we;
            busy_d  = 1'b1;
`ifdef MAINMEM_ERR_EN
            addr_d  = addr;
`else
            idx_d   = addr[ADDR_BITS+1:2];
`endif
        end else if (state_q == BUSY) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                busy_d = 1'b0;
                if (!write_q) begin
                    dram_d = err ? 32'd0 : mem_array[idx];
                end
`ifdef MAINMEM_ERR_EN
                mem_err_d = err;
`endif
            end
        end
    end

    // Array write happens only on the completion edge of a clean write; a reset mid-access never reaches it.
    always_ff @(posedge clk) begin
        if (complete && write_q && !err) begin
            mem_array[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mainmem_ctrl.sv
// Testbench for mainmem_ctrl: directed scenarios plus a randomized mix,
// all checked against a word-array reference model held in the bench.
module tb_mainmem_ctrl;

    localparam int ADDR_BITS = 10;
    localparam int LATENCY   = 4;
    localparam int DEPTH     = 1 << ADDR_BITS;

    logic        clk = 1'b0;
    logic        rst;
    logic        mainmem_access;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] reg_data;
    logic        mainmem_busy;
    logic [31:0] dram_data;
`ifdef MAINMEM_ERR_EN
    logic        mem_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_dram;
    int          written[$];

    mainmem_ctrl #(
        .ADDR_BITS(ADDR_BITS),
        .LATENCY  (LATENCY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mainmem_access(mainmem_access),
        .re            (re),
        .we            (we),
        .addr          (addr),
        .reg_data      (reg_data),
        .mainmem_busy  (mainmem_busy),
        .dram_data     (dram_data)
`ifdef MAINMEM_ERR_EN
        ,
        .mem_err       (mem_err)
`endif
    );

    always #5 clk = ~clk;

    // Word index selected by a byte address: drop the byte offset, wrap to the array depth.
    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Whether an address is flagged as erroneous in this build.
    function automatic bit addr_bad(input logic [31:0] a);
`ifdef MAINMEM_ERR_EN
        return ((a % 4) != 0) || ((a >> (ADDR_BITS + 2)) != 0);
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    // One complete access with the request held high through BUSY and DONE while addr/data are scrambled.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input string tag);
        bit          bad;
        int          idx;
        int          cycles;
        bit          timed_out;
        logic [31:0] exp_dram;
        bad       = addr_bad(a);
        idx       = word_of(a);
        cycles    = 0;
        timed_out = 1'b0;
        exp_dram  = ref_dram;
        if (wr) begin
            if (!bad) begin
                ref_mem[idx] = d;
                written.push_back(idx);
            end
        end else begin
            exp_dram = bad ? 32'd0 : ref_mem[idx];
        end

        @(negedge clk);
        mainmem_access = 1'b1;
        re             = rd;
        we             = wr;
        addr           = a;
        reg_data       = d;
        @(posedge clk);
        #1;
        checks++;
        if (mainmem_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s accept: busy=%b, expected 1", tag, mainmem_busy);
        end

        while (1) begin
            @(negedge clk);
            if (mainmem_busy !== 1'b1) break;
            cycles++;
            addr     = $urandom;
            reg_data = $urandom;
            if (cycles > 40) begin
                timed_out = 1'b1;
                break;
            end
        end
        checks++;
        if (timed_out || cycles != LATENCY) begin
            errors++;
            $display("[TB] FAIL %s busy_len: got %0d cycles, expected %0d", tag, cycles, LATENCY);
        end
        checks++;
        if (dram_data !== exp_dram) begin
            errors++;
            $display("[TB] FAIL %s dram_data: got %h, expected %h", tag, dram_data, exp_dram);
        end
        ref_dram = exp_dram;
`ifdef MAINMEM_ERR_EN
        checks++;
        if (mem_err !== bad) begin
            errors++;
            $display("[TB] FAIL %s mem_err: got %b, expected %b", tag, mem_err, bad);
        end
`endif

        @(negedge clk);
        checks++;
        if (mainmem_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s held_in_done: busy=%b, expected 0", tag, mainmem_busy);
        end
`ifdef MAINMEM_ERR_EN
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s mem_err_pulse: got %b, expected 0", tag, mem_err);
        end
`endif
        mainmem_access = 1'b0;
        re             = 1'b0;
        we             = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        mainmem_access = 1'b1;
        re             = 1'b1;
        we             = 1'b0;
        addr           = 32'h40;
        reg_data       = 32'd0;
        ref_dram       = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (mainmem_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b, expected 0", mainmem_busy);
        end
        checks++;
        if (dram_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_dram: got %h, expected 00000000", dram_data);
        end
`ifdef MAINMEM_ERR_EN
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mem_err: got %b, expected 0", mem_err);
        end
`endif
        mainmem_access = 1'b0;
        re             = 1'b0;
        rst            = 1'b1;
    endtask

    task automatic test_write_read();
        do_access(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, "wr40");
        do_access(1'b1, 1'b0, 32'h40, 32'h0, "rd40");
    endtask

    task automatic test_both_flags();
        do_access(1'b1, 1'b1, 32'h10, 32'h1234_5678, "rewe10");
        do_access(1'b1, 1'b0, 32'h10, 32'h0, "rd10");
    endtask

    task automatic test_no_op();
        @(negedge clk);
        mainmem_access = 1'b1;
        re             = 1'b0;
        we             = 1'b0;
        addr           = 32'h40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mainmem_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL noop_busy[%0d]: got %b, expected 0", i, mainmem_busy);
            end
        end
        checks++;
        if (dram_data !== ref_dram) begin
            errors++;
            $display("[TB] FAIL noop_dram: got %h, expected %h", dram_data, ref_dram);
        end
        mainmem_access = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_access(1'b0, 1'b1, 32'h80, 32'hA5A5_0080, "wr80_prior");
        @(negedge clk);
        mainmem_access = 1'b1;
        re             = 1'b0;
        we             = 1'b1;
        addr           = 32'h80;
        reg_data       = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        checks++;
        if (mainmem_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_accept: busy=%b, expected 1", mainmem_busy);
        end
        @(negedge clk);
        mainmem_access = 1'b0;
        we             = 1'b0;
        rst            = 1'b0;
        #1;
        checks++;
        if (mainmem_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_busy: got %b, expected 0", mainmem_busy);
        end
        checks++;
        if (dram_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_dram: got %h, expected 00000000", dram_data);
        end
        ref_dram = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        do_access(1'b1, 1'b0, 32'h80, 32'h0, "rd80_after_rst");
    endtask

`ifdef MAINMEM_ERR_EN
    task automatic test_err();
        do_access(1'b1, 1'b0, 32'h42, 32'h0, "rd42_err");
        do_access(1'b0, 1'b1, 32'h42, 32'h1111_1111, "wr42_err");
        do_access(1'b0, 1'b1, 32'h1000_0040, 32'h2222_2222, "wrhigh_err");
        do_access(1'b1, 1'b0, 32'h40, 32'h0, "rd40_intact");
    endtask
`else
    task automatic test_truncation();
        do_access(1'b0, 1'b1, 32'hFFFF_F00F, 32'hCAFE_F00D, "wr_trunc");
        do_access(1'b1, 1'b0, 32'h0000_000C, 32'h0, "rd_trunc");
    endtask
`endif

    task automatic test_random();
        int          idx;
        logic [31:0] a;
        logic [31:0] junk;
        bit          do_write;
        for (int n = 0; n < 60; n++) begin
            do_write = (written.size() == 0) || ($urandom_range(0, 1) == 1);
            if (do_write) idx = int'($urandom_range(0, DEPTH - 1));
            else          idx = written[$urandom_range(0, written.size() - 1)];
            a    = 32'(idx) << 2;
            junk = $urandom & ~(32'(DEPTH - 1) << 2);
`ifdef MAINMEM_ERR_EN
            if ($urandom_range(0, 3) == 0) a = a | junk;
`else
            a = a | junk;
`endif
            if (do_write) begin
                do_access($urandom_range(0, 1) == 1, 1'b1, a, $urandom, "rand_wr");
            end else begin
                do_access(1'b1, 1'b0, a, $urandom, "rand_rd");
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_both_flags();
        test_no_op();
        test_mid_reset();
`ifdef MAINMEM_ERR_EN
        test_err();
`else
        test_truncation();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mainmem_ctrl.md
MAINMEM_CTRL -- requirements
Module: mainmem_ctrl

Interface
REQ-001 Parameter ADDR_BITS, default 10; word-array depth is 2**ADDR_BITS 32-bit words.
REQ-002 Parameter LATENCY, default 4, legal range 1..15; the number of cycles mainmem_busy stays high per access.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 mainmem_access  input  1  access request from the cache.
REQ-006 re  input  1  read request qualifier.
REQ-007 we  input  1  write request qualifier.
REQ-008 addr  input  32  byte address; word index is addr[ADDR_BITS+1:2].
REQ-009 reg_data  input  32  write data.
REQ-010 mainmem_busy  output  1  high while an access is in progress.
REQ-011 dram_data  output  32  registered read data.
REQ-012 mem_err  output  1  error pulse; present only when MAINMEM_ERR_EN is defined.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 In IDLE, at an edge sampling mainmem_access=1 with re or we high, the block SHALL latch addr, reg_data and the op, set mainmem_busy to 1, load the counter with LATENCY-1, and enter BUSY.
REQ-015 In IDLE, mainmem_access=1 with re=0 and we=0 SHALL be ignored.
REQ-016 When re=1 and we=1 together, the access SHALL be a write only.
REQ-017 In BUSY, the counter SHALL decrement each edge, and inputs SHALL be ignored because the latched values are used.
REQ-018 In BUSY with counter=0, the block SHALL perform the latched op, clear mainmem_busy, and enter DONE, so busy is high for exactly LATENCY cycles.
REQ-019 A read SHALL load dram_data from the array at the same edge that mainmem_busy falls.
REQ-020 A write SHALL update the array at the completion edge, and dram_data SHALL be unchanged.
REQ-021 DONE SHALL last one cycle with mainmem_busy=0, ignore mainmem_access, and return to IDLE, so a new access is accepted no earlier than 2 cycles after busy falls.
REQ-022 dram_data SHALL hold the last read value until the next read completes.
REQ-023 Address bits above ADDR_BITS+1 and bits [1:0] SHALL be ignored unless MAINMEM_ERR_EN is defined.

Reset
REQ-024 While rst=0, the block SHALL set the FSM to IDLE, mainmem_busy=0, dram_data=0, counter=0 and mem_err=0, taking effect immediately.
REQ-025 Reset during BUSY SHALL abort the access with no array write.
REQ-026 The array contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro MAINMEM_ERR_EN defined: mem_err SHALL pulse high for one cycle at the completion edge when latched addr[1:0]!=0 or any addr bit above ADDR_BITS+1 is nonzero.
REQ-028 With MAINMEM_ERR_EN defined, an errored write SHALL be suppressed, an errored read SHALL return 0, and busy timing SHALL be unchanged.
REQ-029 Macro MAINMEM_ERR_EN undefined: the mem_err port and its logic SHALL be absent, and addresses SHALL be truncated per REQ-023.

Verification
REQ-030 Write then read, LATENCY=4: write 0xDEADBEEF to addr 0x40, then read 0x40 -> busy high exactly 4 cycles each, and dram_data=0xDEADBEEF on the edge busy falls.
REQ-031 Held request: keep mainmem_access high through DONE -> no second access, and busy stays low 1 cycle after falling.
REQ-032 Input change during BUSY: change addr/reg_data while busy -> the original latched address and data are used.
REQ-033 Mid-access reset: assert rst=0 in cycle 2 of a write to 0x80 -> busy=0 immediately, and a later read of 0x80 returns the prior contents.
REQ-034 Simultaneous re=we=1 with data 0x12345678 at 0x10 -> write performed, dram_data unchanged, and a later read returns 0x12345678.
REQ-035 MAINMEM_ERR_EN defined: read addr 0x42 -> mem_err pulses one cycle at completion, dram_data=0, and busy is high for LATENCY cycles.
